// File: rtl/gyruss_sndcmd_rx_if.sv
// Sound-command bus between the main-CPU command outputs / sound-CPU
// strobes and the sound-side command receiver.
// Signal suffixes are named from the receiver's point of view.
interface gyruss_sndcmd_rx_if #(
    parameter int CW = 3
);
    logic          sndRq_i;
    logic [7:0]    sndNo_i;
    logic          csRd_i;
    logic          iAck_i;
    logic [7:0]    rdDt_o;
    logic          irq_o;
    logic [CW-1:0] count_o;
    logic          ovf_o;

    // Drives requests and strobes and watches the receiver's outputs.
    modport master (
        output sndRq_i, sndNo_i, csRd_i, iAck_i,
        input  rdDt_o, irq_o, count_o, ovf_o
    );

    // The receiver itself.
    modport slave (
        input  sndRq_i, sndNo_i, csRd_i, iAck_i,
        output rdDt_o, irq_o, count_o, ovf_o
    );
endinterface

// File: rtl/gyruss_sndcmd_rx.sv
// Sound-side receiver for main-CPU sound commands.
// Each rising edge of the request line queues the command byte in a small
// FIFO. The sound CPU is interrupted while entries are waiting. Each read
// strobe pops the head entry. A command that arrives while the FIFO is full
// is dropped, and that loss is recorded in a sticky overflow flag.
module gyruss_sndcmd_rx #(
    parameter int QDEPTH = 4,
    parameter int CW     = 3
) (
    input logic                  mclk_i,
    input logic                  reset_i,
    gyruss_sndcmd_rx_if.slave    bus
);

    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(QDEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    logic [7:0]    mem_q [QDEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    last_q, last_d;
    logic          ovf_q, ovf_d;
    logic          rqPrev_q, rqPrev_d;
    state_t        state_q, state_d;

    logic          pushReq;
    logic          pushOk;
    logic          popOk;
    logic          isFull;
    logic          isEmpty;

    // Queue bookkeeping: edge detect, push/pop acceptance, pointers, count, overflow.
    always_comb begin
        rqPrev_d = bus.sndRq_i;
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        count_d  = count_q;
        last_d   = last_q;
        ovf_d    = ovf_q;

        isEmpty  = (count_q == '0);
        isFull   = (count_q == CNT_FULL);
        pushReq  = bus.sndRq_i && !rqPrev_q;
        popOk    = bus.csRd_i && !isEmpty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        pushOk   = pushReq && (!isFull || popOk);

        if (pushOk) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
        end
        if (pushReq && !pushOk) begin
            ovf_d = 1'b1;
        end
        if (popOk) begin
            rdPtr_d = rdPtr_q + PTR_ONE;
            last_d  = mem_q[rdPtr_q];
        end

        case ({pushOk, popOk})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Interrupt handshake: raise while entries wait, park after an ack, drop on a read.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!isEmpty) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (popOk) begin
                    state_d = ST_IDLE;
                end else if (bus.iAck_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (popOk) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and status registers; the edge register comes out of reset high
    // so a request already held high is not mistaken for a new command.
    always_ff @(posedge mclk_i) begin
        if (reset_i) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            last_q   <= 8'h00;
            ovf_q    <= 1'b0;
            rqPrev_q <= 1'b1;
            state_q  <= ST_IDLE;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            rqPrev_q <= rqPrev_d;
            state_q  <= state_d;
        end
    end

    // Storage array; contents need no reset because the count governs validity.
    always_ff @(posedge mclk_i) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= bus.sndNo_i;
        end
    end

    assign bus.rdDt_o  = isEmpty ? last_q : mem_q[rdPtr_q];
    assign bus.irq_o   = (state_q == ST_ASSERT);
    assign bus.count_o = count_q;
    assign bus.ovf_o   = ovf_q;

endmodule

// File: tb/tb_gyruss_sndcmd_rx.sv
// Bench for the sound-command receiver. Commands are mirrored into a
// scoreboard queue as they are sent, and read data is compared against the
// queue head when the sound CPU pops.
module tb_gyruss_sndcmd_rx;

    localparam int QDEPTH = 4;
    localparam int CW     = 3;

    logic mclk;
    logic reset;

    gyruss_sndcmd_rx_if #(.CW(CW)) bus ();

    gyruss_sndcmd_rx #(
        .QDEPTH(QDEPTH),
        .CW(CW)
    ) dut (
        .mclk_i(mclk),
        .reset_i(reset),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] sb[$];
    int         mCount;
    logic [7:0] mLast;
    logic       mOvf;

    // Free-running clock.
    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    // Hard stop in case the run ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic clearModel();
        sb.delete();
        mCount = 0;
        mLast  = 8'h00;
        mOvf   = 1'b0;
    endtask

    // Drive all bus inputs for one cycle, then return them to idle.
    task automatic applyStimulus(input logic rq, input logic [7:0] no,
                                 input logic rd, input logic ack);
        bus.sndRq_i = rq;
        bus.sndNo_i = no;
        bus.csRd_i  = rd;
        bus.iAck_i  = ack;
        tick();
        bus.csRd_i  = 1'b0;
        bus.iAck_i  = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        bus.sndRq_i = 1'b0;
        bus.sndNo_i = 8'h00;
        bus.csRd_i  = 1'b0;
        bus.iAck_i  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        clearModel();
        tick();
    endtask

    // One command: request high for one cycle, then low for one cycle.
    task automatic pushCmd(input logic [7:0] b);
        if (mCount < QDEPTH) begin
            sb.push_back(b);
            mCount++;
        end else begin
            mOvf = 1'b1;
        end
        applyStimulus(1'b1, b, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // One read strobe; returns what the CPU saw and what the model predicts.
    task automatic popCmd(output logic [7:0] seen, output logic [7:0] exp);
        bus.csRd_i = 1'b1;
        seen = bus.rdDt_o;
        if (mCount > 0) begin
            exp = sb.pop_front();
            mCount--;
            mLast = exp;
        end else begin
            exp = mLast;
        end
        tick();
        bus.csRd_i = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        total++; if (bus.count_o !== CW'(0)) begin bad++; $display("[TB] FAIL rst_count got=%0d exp=0", bus.count_o); end
        total++; if (bus.irq_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_irq got=%b exp=0", bus.irq_o); end
        total++; if (bus.ovf_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_ovf got=%b exp=0", bus.ovf_o); end
        total++; if (bus.rdDt_o !== 8'h00) begin bad++; $display("[TB] FAIL rst_rddt got=%h exp=00", bus.rdDt_o); end
    endtask

    task automatic test_single();
        logic [7:0] seen, exp;
        doReset();
        sb.push_back(8'h5A);
        mCount++;
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        total++; if (bus.count_o !== CW'(1)) begin bad++; $display("[TB] FAIL t1_count1 got=%0d exp=1", bus.count_o); end
        total++; if (bus.irq_o !== 1'b0) begin bad++; $display("[TB] FAIL t1_irq_early got=%b exp=0", bus.irq_o); end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        total++; if (bus.irq_o !== 1'b1) begin bad++; $display("[TB] FAIL t1_irq_rise got=%b exp=1", bus.irq_o); end
        total++; if (bus.rdDt_o !== 8'h5A) begin bad++; $display("[TB] FAIL t1_rddt got=%h exp=5a", bus.rdDt_o); end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        total++; if (bus.irq_o !== 1'b0) begin bad++; $display("[TB] FAIL t1_irq_ack got=%b exp=0", bus.irq_o); end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        popCmd(seen, exp);
        total++; if (seen !== exp) begin bad++; $display("[TB] FAIL t1_read got=%h exp=%h", seen, exp); end
        total++; if (bus.count_o !== CW'(0)) begin bad++; $display("[TB] FAIL t1_count0 got=%0d exp=0", bus.count_o); end
        total++; if (bus.rdDt_o !== 8'h5A) begin bad++; $display("[TB] FAIL t1_rddt_last got=%h exp=5a", bus.rdDt_o); end
    endtask

    task automatic test_overflow();
        logic [7:0] seen, exp;
        doReset();
        for (int i = 1; i <= 5; i++) pushCmd(8'(i));
        total++; if (bus.count_o !== CW'(mCount)) begin bad++; $display("[TB] FAIL t2_count got=%0d exp=%0d", bus.count_o, mCount); end
        total++; if (bus.ovf_o !== mOvf) begin bad++; $display("[TB] FAIL t2_ovf got=%b exp=%b", bus.ovf_o, mOvf); end
        for (int i = 0; i < 5; i++) begin
            popCmd(seen, exp);
            total++; if (seen !== exp) begin bad++; $display("[TB] FAIL t2_read%0d got=%h exp=%h", i, seen, exp); end
        end
        total++; if (bus.rdDt_o !== 8'h04) begin bad++; $display("[TB] FAIL t2_rddt_last got=%h exp=04", bus.rdDt_o); end
        total++; if (bus.count_o !== CW'(0)) begin bad++; $display("[TB] FAIL t2_count0 got=%0d exp=0", bus.count_o); end
    endtask

    task automatic test_full_pushpop();
        logic [7:0] seen, exp;
        doReset();
        for (int i = 0; i < 4; i++) pushCmd(8'h11 + 8'(i));
        total++; if (bus.count_o !== CW'(4)) begin bad++; $display("[TB] FAIL t3_full got=%0d exp=4", bus.count_o); end
        bus.sndRq_i = 1'b1;
        bus.sndNo_i = 8'h15;
        popCmd(seen, exp);
        sb.push_back(8'h15);
        mCount++;
        bus.sndRq_i = 1'b0;
        total++; if (seen !== exp) begin bad++; $display("[TB] FAIL t3_read got=%h exp=%h", seen, exp); end
        total++; if (bus.count_o !== CW'(mCount)) begin bad++; $display("[TB] FAIL t3_count got=%0d exp=%0d", bus.count_o, mCount); end
        total++; if (bus.ovf_o !== 1'b0) begin bad++; $display("[TB] FAIL t3_ovf got=%b exp=0", bus.ovf_o); end
        tick();
        for (int i = 0; i < 4; i++) begin
            popCmd(seen, exp);
            total++; if (seen !== exp) begin bad++; $display("[TB] FAIL t3_drain%0d got=%h exp=%h", i, seen, exp); end
        end
    endtask

    task automatic test_ack_requeue();
        logic [7:0] seen, exp;
        doReset();
        pushCmd(8'hA1);
        pushCmd(8'hA2);
        total++; if (bus.irq_o !== 1'b1) begin bad++; $display("[TB] FAIL t4_irq got=%b exp=1", bus.irq_o); end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        total++; if (bus.irq_o !== 1'b0) begin bad++; $display("[TB] FAIL t4_irq_ack got=%b exp=0", bus.irq_o); end
        popCmd(seen, exp);
        total++; if (seen !== exp) begin bad++; $display("[TB] FAIL t4_read1 got=%h exp=%h", seen, exp); end
        total++; if (bus.irq_o !== 1'b0) begin bad++; $display("[TB] FAIL t4_irq_p1 got=%b exp=0", bus.irq_o); end
        tick();
        total++; if (bus.irq_o !== 1'b1) begin bad++; $display("[TB] FAIL t4_irq_p2 got=%b exp=1", bus.irq_o); end
        total++; if (bus.rdDt_o !== sb[0]) begin bad++; $display("[TB] FAIL t4_head got=%h exp=%h", bus.rdDt_o, sb[0]); end
        popCmd(seen, exp);
        total++; if (seen !== exp) begin bad++; $display("[TB] FAIL t4_read2 got=%h exp=%h", seen, exp); end
        total++; if (bus.count_o !== CW'(0)) begin bad++; $display("[TB] FAIL t4_count got=%0d exp=0", bus.count_o); end
        tick();
        total++; if (bus.irq_o !== 1'b0) begin bad++; $display("[TB] FAIL t4_irq_stay got=%b exp=0", bus.irq_o); end
    endtask

    task automatic test_reset_hold();
        reset = 1'b1;
        applyStimulus(1'b1, 8'h66, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h66, 1'b0, 1'b0);
        reset = 1'b0;
        clearModel();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h66, 1'b0, 1'b0);
        total++; if (bus.count_o !== CW'(0)) begin bad++; $display("[TB] FAIL t5_held got=%0d exp=0", bus.count_o); end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        pushCmd(8'h77);
        total++; if (bus.count_o !== CW'(mCount)) begin bad++; $display("[TB] FAIL t5_one got=%0d exp=%0d", bus.count_o, mCount); end
        pushCmd(8'h78);
        pushCmd(8'h79);
        total++; if (bus.count_o !== CW'(3)) begin bad++; $display("[TB] FAIL t5_three got=%0d exp=3", bus.count_o); end
        reset = 1'b1;
        tick();
        total++; if (bus.count_o !== CW'(0)) begin bad++; $display("[TB] FAIL t5_flush_count got=%0d exp=0", bus.count_o); end
        total++; if (bus.irq_o !== 1'b0) begin bad++; $display("[TB] FAIL t5_flush_irq got=%b exp=0", bus.irq_o); end
        total++; if (bus.ovf_o !== 1'b0) begin bad++; $display("[TB] FAIL t5_flush_ovf got=%b exp=0", bus.ovf_o); end
        total++; if (bus.rdDt_o !== 8'h00) begin bad++; $display("[TB] FAIL t5_flush_rddt got=%h exp=00", bus.rdDt_o); end
        reset = 1'b0;
        clearModel();
        tick();
    endtask

    task automatic test_polled();
        logic [7:0] seen, exp;
        doReset();
        pushCmd(8'h3C);
        total++; if (bus.irq_o !== 1'b1) begin bad++; $display("[TB] FAIL t6_irq got=%b exp=1", bus.irq_o); end
        popCmd(seen, exp);
        total++; if (seen !== exp) begin bad++; $display("[TB] FAIL t6_read got=%h exp=%h", seen, exp); end
        total++; if (bus.irq_o !== 1'b0) begin bad++; $display("[TB] FAIL t6_irq_pop got=%b exp=0", bus.irq_o); end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        total++; if (bus.irq_o !== 1'b0) begin bad++; $display("[TB] FAIL t6_stray_ack got=%b exp=0", bus.irq_o); end
        total++; if (bus.count_o !== CW'(0)) begin bad++; $display("[TB] FAIL t6_count got=%0d exp=0", bus.count_o); end
        total++; if (bus.rdDt_o !== 8'h3C) begin bad++; $display("[TB] FAIL t6_rddt got=%h exp=3c", bus.rdDt_o); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        reset = 1'b1;
        bus.sndRq_i = 1'b0;
        bus.sndNo_i = 8'h00;
        bus.csRd_i  = 1'b0;
        bus.iAck_i  = 1'b0;
        clearModel();
        test_reset();
        test_single();
        test_overflow();
        test_full_pushpop();
        test_ack_requeue();
        test_reset_hold();
        test_polled();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
